// File: rtl/gan_host_sequencer.sv
// gan_host_sequencer
// Sequences one GAN inference per host request. The request latents and the
// 20-bit per-cycle choice pattern are latched, the core is held in reset for
// one cycle and then run. The first discriminator-finish captures the nine
// generated pixels plus the score, which are streamed out as ten words. A run
// that exceeds TIMEOUT cycles is aborted with a sticky timeout flag.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_in_1, req_in_2            signed latent inputs (latched on accept)
//   req_choice                    per-cycle choice bits, LSB used first
//   core_rst                      synchronous reset to the GAN core
//   core_in_1, core_in_2          latents presented to the core during RUN
//   core_choice                   current choice bit during RUN
//   core_gen_finish               core generator done
//   core_disc_finish              core discriminator done (triggers capture)
//   core_pixels                   9 pixel words, 1x1 in the LSBs, 3x3 in the MSBs
//   core_out_disc                 discriminator score
//   out_valid/out_ready           result stream handshake
//   out_data, out_idx, out_last   result word, its index 0..9, last marker
//   busy                          transaction in progress
//   timeout_err, seq_err          sticky error flags, cleared on next accept
module gan_host_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic signed [WIDTH-1:0] req_in_1,
    input  logic signed [WIDTH-1:0] req_in_2,
    input  logic [19:0]             req_choice,
    output logic                    core_rst,
    output logic signed [WIDTH-1:0] core_in_1,
    output logic signed [WIDTH-1:0] core_in_2,
    output logic                    core_choice,
    input  logic                    core_gen_finish,
    input  logic                    core_disc_finish,
    input  logic [9*WIDTH-1:0]      core_pixels,
    input  logic signed [WIDTH-1:0] core_out_disc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [3:0]              out_idx,
    output logic                    out_last,
    output logic                    busy,
    output logic                    timeout_err,
    output logic                    seq_err
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RST_CORE = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;
    localparam logic [1:0] S_SEND     = 2'd3;

    // The step counter must hold TIMEOUT and also index all 20 choice bits.
    localparam int STEP_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

    localparam logic [STEP_W-1:0] STEP_MAX    = STEP_W'(TIMEOUT);
    localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(TIMEOUT - 1);
    localparam logic [STEP_W-1:0] CHOICE_LAST = STEP_W'(19);
    localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

    logic [1:0]              state;
    logic [WIDTH-1:0]        lat_in_1;
    logic [WIDTH-1:0]        lat_in_2;
    logic [19:0]             lat_choice;
    logic [STEP_W-1:0]       step;
    logic [3:0]              idx;
    logic [WIDTH-1:0]        pix_buf [0:9];

    // Sequencer state, request latches, step/index counters, capture buffer and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            lat_in_1    <= {WIDTH{1'b0}};
            lat_in_2    <= {WIDTH{1'b0}};
            lat_choice  <= 20'd0;
            step        <= {STEP_W{1'b0}};
            idx         <= 4'd0;
            timeout_err <= 1'b0;
            seq_err     <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                pix_buf[i] <= {WIDTH{1'b0}};
            end
        end else begin
            case (state)
                S_IDLE: begin
                    // req_ready is high throughout IDLE, so req_valid alone is a handshake.
                    if (req_valid) begin
                        lat_in_1    <= req_in_1;
                        lat_in_2    <= req_in_2;
                        lat_choice  <= req_choice;
                        timeout_err <= 1'b0;
                        seq_err     <= 1'b0;
                        state       <= S_RST_CORE;
                    end
                end
                S_RST_CORE: begin
                    step  <= {STEP_W{1'b0}};
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (step != STEP_MAX) begin
                        step <= step + STEP_ONE;
                    end
                    // Capture takes priority over the timeout in the same cycle.
                    if (core_disc_finish) begin
                        for (int i = 0; i < 9; i++) begin
                            pix_buf[i] <= core_pixels[i*WIDTH +: WIDTH];
                        end
                        pix_buf[9] <= core_out_disc;
                        idx        <= 4'd0;
                        if (!core_gen_finish) begin
                            seq_err <= 1'b1;
                        end
                        state <= S_SEND;
                    end else if (step >= STEP_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (idx == 4'd9) begin
                            idx   <= 4'd0;
                            state <= S_IDLE;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode: every output is a pure function of the registered state above.
    always_comb begin
        req_ready   = 1'b0;
        core_rst    = 1'b1;
        core_in_1   = {WIDTH{1'b0}};
        core_in_2   = {WIDTH{1'b0}};
        core_choice = 1'b0;
        out_valid   = 1'b0;
        out_data    = {WIDTH{1'b0}};
        out_idx     = 4'd0;
        out_last    = 1'b0;
        busy        = 1'b1;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_RST_CORE: begin
                core_rst = 1'b1;
            end
            S_RUN: begin
                core_rst    = 1'b0;
                core_in_1   = lat_in_1;
                core_in_2   = lat_in_2;
                core_choice = (step <= CHOICE_LAST) ? lat_choice[step[4:0]] : 1'b0;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_idx   = idx;
                out_data  = (idx <= 4'd9) ? pix_buf[idx] : {WIDTH{1'b0}};
                out_last  = (idx == 4'd9);
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_gan_host_sequencer.sv
// Self-checking bench for gan_host_sequencer: directed scenarios followed by
// randomized transactions, each checked against a transaction-level model of
// the expected handshake, run, capture and streaming behaviour.
module tb_gan_host_sequencer;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 40;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_valid;
    logic                    req_ready;
    logic signed [WIDTH-1:0] req_in_1;
    logic signed [WIDTH-1:0] req_in_2;
    logic [19:0]             req_choice;
    logic                    core_rst;
    logic signed [WIDTH-1:0] core_in_1;
    logic signed [WIDTH-1:0] core_in_2;
    logic                    core_choice;
    logic                    core_gen_finish;
    logic                    core_disc_finish;
    logic [9*WIDTH-1:0]      core_pixels;
    logic signed [WIDTH-1:0] core_out_disc;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [3:0]              out_idx;
    logic                    out_last;
    logic                    busy;
    logic                    timeout_err;
    logic                    seq_err;

    int n_checks = 0;
    int n_pass   = 0;
    int acc_cnt  = 0;

    always #5 clk = ~clk;

    gan_host_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_in_1         (req_in_1),
        .req_in_2         (req_in_2),
        .req_choice       (req_choice),
        .core_rst         (core_rst),
        .core_in_1        (core_in_1),
        .core_in_2        (core_in_2),
        .core_choice      (core_choice),
        .core_gen_finish  (core_gen_finish),
        .core_disc_finish (core_disc_finish),
        .core_pixels      (core_pixels),
        .core_out_disc    (core_out_disc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_idx          (out_idx),
        .out_last         (out_last),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .seq_err          (seq_err)
    );

    // Count request acceptances seen on the bus.
    always @(posedge clk) begin
        if (!rst && req_valid && req_ready) acc_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Random core inputs; outside the capture cycle these must have no effect.
    task automatic drive_garbage(input bit disc);
        for (int i = 0; i < 9; i++) core_pixels[i*WIDTH +: WIDTH] = $urandom;
        core_out_disc    = $urandom;
        core_gen_finish  = 1'($urandom);
        core_disc_finish = disc;
    endtask

    // One request from IDLE to completion; starts and ends at a falling edge.
    // gen_at/disc_at: RUN cycle (0-based) where gen_finish rises (and stays) /
    // disc_finish pulses, -1 for never. ready_mode: 0 always, 1 pattern 1,0,0,1,
    // 2 random. rst_at: SEND index at which reset is pulsed, -1 for none.
    task automatic do_txn(input logic [31:0] in1, input logic [31:0] in2, input logic [19:0] ch,
                          input int gen_at, input int disc_at, input int ready_mode,
                          input int rst_at, input bit fixed_pix, input bit hold_valid);
        logic [31:0] exp_buf [10];
        bit   captured;
        bit   exp_seq;
        bit   exp_ch;
        int   acc0;
        int   k;
        int   cyc;

        check("idle_req_ready", req_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_core_rst", core_rst, 1);
        check("idle_out_valid", out_valid, 0);
        acc0       = acc_cnt;
        req_valid  = 1'b1;
        req_in_1   = in1;
        req_in_2   = in2;
        req_choice = ch;
        drive_garbage(1'b1);
        @(posedge clk); @(negedge clk);

        check("accept_once", acc_cnt - acc0, 1);
        check("rstc_req_ready", req_ready, 0);
        check("rstc_busy", busy, 1);
        check("rstc_core_rst", core_rst, 1);
        check("rstc_core_in_1", core_in_1, 0);
        check("rstc_core_choice", core_choice, 0);
        check("rstc_timeout_clr", timeout_err, 0);
        check("rstc_seq_clr", seq_err, 0);
        req_valid  = hold_valid;
        req_in_1   = $urandom;
        req_in_2   = $urandom;
        req_choice = 20'($urandom);
        drive_garbage(1'b1);
        @(posedge clk); @(negedge clk);

        captured = 1'b0;
        exp_seq  = 1'b0;
        for (int r = 0; r < TIMEOUT; r++) begin
            exp_ch = (r < 20) ? ch[r] : 1'b0;
            check("run_core_rst", core_rst, 0);
            check("run_req_ready", req_ready, 0);
            check("run_busy", busy, 1);
            check("run_core_in_1", core_in_1, in1);
            check("run_core_in_2", core_in_2, in2);
            check("run_core_choice", core_choice, exp_ch);
            check("run_out_valid", out_valid, 0);
            req_in_1   = $urandom;
            req_in_2   = $urandom;
            req_choice = 20'($urandom);
            drive_garbage(r == disc_at);
            core_gen_finish = (gen_at >= 0) && (r >= gen_at);
            if (r == disc_at) begin
                for (int i = 0; i < 9; i++) begin
                    exp_buf[i] = fixed_pix ? 32'(i + 1) : $urandom;
                    core_pixels[i*WIDTH +: WIDTH] = exp_buf[i];
                end
                exp_buf[9]    = fixed_pix ? 32'h0000_007F : $urandom;
                core_out_disc = exp_buf[9];
                exp_seq       = !core_gen_finish;
                captured      = 1'b1;
            end
            @(posedge clk); @(negedge clk);
            if (captured) break;
        end

        if (!captured) begin
            check("to_timeout_err", timeout_err, 1);
            check("to_busy", busy, 0);
            check("to_req_ready", req_ready, 1);
            check("to_out_valid", out_valid, 0);
            check("to_seq_err", seq_err, 0);
        end else begin
            k   = 0;
            cyc = 0;
            while (k < 10 && cyc < 200) begin
                check("send_out_valid", out_valid, 1);
                check("send_out_idx", out_idx, k);
                check("send_out_data", out_data, exp_buf[k]);
                check("send_out_last", out_last, (k == 9) ? 1 : 0);
                check("send_seq_err", seq_err, exp_seq);
                check("send_timeout_err", timeout_err, 0);
                check("send_busy", busy, 1);
                check("send_req_ready", req_ready, 0);
                check("send_core_rst", core_rst, 1);
                check("send_core_in_1", core_in_1, 0);
                check("send_core_choice", core_choice, 0);
                if (k == rst_at) begin
                    rst       = 1'b1;
                    req_valid = 1'b0;
                    out_ready = 1'b0;
                    #1;
                    check("arst_out_valid", out_valid, 0);
                    check("arst_core_rst", core_rst, 1);
                    check("arst_busy", busy, 0);
                    check("arst_req_ready", req_ready, 1);
                    check("arst_out_data", out_data, 0);
                    check("arst_seq_err", seq_err, 0);
                    @(posedge clk); @(negedge clk);
                    check("arst_hold_valid", out_valid, 0);
                    rst = 1'b0;
                    return;
                end
                drive_garbage(1'b1);
                case (ready_mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: out_ready = 1'($urandom);
                endcase
                @(posedge clk); @(negedge clk);
                if (out_ready) k++;
                cyc++;
            end
            check("send_handshakes", k, 10);
            check("done_out_valid", out_valid, 0);
            check("done_busy", busy, 0);
            check("done_req_ready", req_ready, 1);
            check("done_seq_sticky", seq_err, exp_seq);
            check("done_core_rst", core_rst, 1);
            out_ready = 1'b0;
        end
        if (!hold_valid) req_valid = 1'b0;
        drive_garbage(1'b0);
        check("no_extra_accept", acc_cnt - acc0, 1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_in_1   = '0;
        req_in_2   = '0;
        req_choice = '0;
        out_ready  = 1'b0;
        core_gen_finish  = 1'b0;
        core_disc_finish = 1'b0;
        core_pixels      = '0;
        core_out_disc    = '0;
        #1;
        check("reset_req_ready", req_ready, 1);
        check("reset_core_rst", core_rst, 1);
        check("reset_busy", busy, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_idx", out_idx, 0);
        check("reset_out_last", out_last, 0);
        check("reset_timeout_err", timeout_err, 0);
        check("reset_seq_err", seq_err, 0);
        check("reset_core_in_1", core_in_1, 0);
        check("reset_core_in_2", core_in_2, 0);
        check("reset_core_choice", core_choice, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reference transaction: gen at RUN cycle 11, disc at 21 (1-based), stalling sink.
        do_txn(32'h0001_0000, 32'hFFFF_0000, 20'hA5A5A, 10, 20, 1, -1, 1'b1, 1'b0);
        // Timeout, then a request that clears the flag.
        do_txn($urandom, $urandom, 20'($urandom), 3, -1, 0, -1, 1'b0, 1'b0);
        // Sequence error: disc without gen, all words still delivered.
        do_txn($urandom, $urandom, 20'($urandom), -1, 15, 0, -1, 1'b0, 1'b0);
        // Capture in the timeout cycle wins.
        do_txn($urandom, $urandom, 20'($urandom), 5, TIMEOUT - 1, 2, -1, 1'b0, 1'b0);
        // Reset in the middle of SEND, then a fresh request.
        do_txn($urandom, $urandom, 20'($urandom), 2, 8, 0, 4, 1'b0, 1'b0);
        do_txn($urandom, $urandom, 20'($urandom), 0, 0, 2, -1, 1'b0, 1'b0);
        // req_valid held across back-to-back transactions.
        do_txn($urandom, $urandom, 20'($urandom), 4, 12, 2, -1, 1'b0, 1'b1);
        do_txn($urandom, $urandom, 20'($urandom), 6, 25, 1, -1, 1'b0, 1'b1);
        do_txn($urandom, $urandom, 20'($urandom), 1, 30, 0, -1, 1'b0, 1'b0);

        for (int t = 0; t < 14; t++) begin
            do_txn($urandom, $urandom, 20'($urandom),
                   ($urandom % 4 == 0) ? -1 : int'($urandom % 30),
                   ($urandom % 8 == 0) ? -1 : int'($urandom % TIMEOUT),
                   int'($urandom % 3),
                   ($urandom % 6 == 0) ? int'($urandom % 10) : -1,
                   1'b0, 1'($urandom));
        end
        req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("final_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
